// File: rtl/unary_stream_decoder_pkg.sv
// Shared definitions for unary stream decoders.
//   udec_state_e : decoder FSM states (IDLE / RUN / HOLD)
//   udec_scale() : converts a window ones-count to a binary result, with
//                  saturation when every sample in the window was a one.
package unary_stream_decoder_pkg;

  typedef enum logic [1:0] {
    UDEC_IDLE = 2'd0,
    UDEC_RUN  = 2'd1,
    UDEC_HOLD = 2'd2
  } udec_state_e;

  // ones    : ones counted over the window, 0 .. 2^logwin (zero-extended)
  // logwin  : log2 of window length, must be >= bitwidth
  // bitwidth: width of the binary result (< 32)
  // A full window (2^logwin ones) would need one extra result bit, so it
  // is clamped to the largest representable value instead.
  function automatic logic [31:0] udec_scale(input logic [32:0] ones,
                                             input int unsigned logwin,
                                             input int unsigned bitwidth);
    logic [32:0] full;
    full = 33'd1 << logwin;
    if (ones >= full) return (32'd1 << bitwidth) - 32'd1;
    return 32'(ones >> (logwin - bitwidth));
  endfunction

endpackage

// File: rtl/unary_stream_decoder_if.sv
// Stream-in / result-out signal bundle for unary_stream_decoder.
//   iStart, iEn, iBit, iClr : conversion control and unary sample stream
//   iReady                  : downstream accepts the result
//   oBin, oValid            : registered result and its valid flag
//   oBusy                   : decoder is accumulating a window
// slave modport is the decoder side, master modport the driver side.
interface unary_stream_decoder_if #(
  parameter int BITWIDTH = 8
);
  logic                iStart;
  logic                iEn;
  logic                iBit;
  logic                iClr;
  logic                iReady;
  logic [BITWIDTH-1:0] oBin;
  logic                oValid;
  logic                oBusy;

  modport master (
    output iStart, iEn, iBit, iClr, iReady,
    input  oBin, oValid, oBusy
  );

  modport slave (
    input  iStart, iEn, iBit, iClr, iReady,
    output oBin, oValid, oBusy
  );
endinterface

// File: rtl/unary_window_counter.sv
// Ones / sample counters for one unary conversion window.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous clear of both counters (has priority)
//   en         : stream_bit is a sample to accumulate this cycle
//   stream_bit : unary sample
//   count      : ones seen so far in the window (LOGWIN+1 bits, never wraps)
//   last       : sample counter is at the final slot of the window
module unary_window_counter #(
  parameter int LOGWIN = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic            stream_bit,
  output logic [LOGWIN:0] count,
  output logic            last
);

  logic [LOGWIN-1:0] samples_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      samples_q <= '0;
    end else if (clear) begin
      count     <= '0;
      samples_q <= '0;
    end else if (en) begin
      count     <= count + (LOGWIN+1)'(stream_bit);
      // Wraps to zero exactly as the window completes.
      samples_q <= samples_q + LOGWIN'(1);
    end
  end

  assign last = &samples_q;

endmodule

// File: rtl/unary_stream_decoder.sv
// Rate-coded unary stream to binary converter.
// Counts ones over 2^LOGWIN enabled samples, then presents the scaled
// count on a valid/ready handshake and holds it until consumed.
//   iClk  : clock, rising edge
//   iRstN : asynchronous active-low reset
//   bus   : stream inputs, iClr abort, iReady, and oBin/oValid/oBusy outputs
module unary_stream_decoder
  import unary_stream_decoder_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int LOGWIN   = 8
) (
  input  logic                   iClk,
  input  logic                   iRstN,
  unary_stream_decoder_if.slave  bus
);

  if (LOGWIN < BITWIDTH) begin : g_bad_params
    $error("unary_stream_decoder: LOGWIN must be >= BITWIDTH");
  end

  udec_state_e         state_q, state_d;
  logic                valid_q, valid_d;
  logic [BITWIDTH-1:0] bin_q, bin_d;
  logic                cnt_clear;
  logic                cnt_en;
  logic [LOGWIN:0]     ones;
  logic                last;
  logic [LOGWIN:0]     final_ones;

  // Samples only count while accumulating; an abort in the same cycle wins.
  assign cnt_en = (state_q == UDEC_RUN) && bus.iEn && !bus.iClr;

  unary_window_counter #(
    .LOGWIN (LOGWIN)
  ) u_counter (
    .clk        (iClk),
    .rst_n      (iRstN),
    .clear      (cnt_clear),
    .en         (cnt_en),
    .stream_bit (bus.iBit),
    .count      (ones),
    .last       (last)
  );

  // The result must include the sample arriving on the closing edge.
  assign final_ones = ones + (LOGWIN+1)'(bus.iBit);

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    bin_d     = bin_q;
    cnt_clear = 1'b0;

    if (bus.iClr) begin
      state_d   = UDEC_IDLE;
      valid_d   = 1'b0;
      bin_d     = '0;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        UDEC_IDLE: begin
          if (bus.iStart) begin
            state_d   = UDEC_RUN;
            cnt_clear = 1'b1;
          end
        end
        UDEC_RUN: begin
          if (bus.iEn && last) begin
            state_d = UDEC_HOLD;
            valid_d = 1'b1;
            bin_d   = BITWIDTH'(udec_scale(33'(final_ones), LOGWIN, BITWIDTH));
          end
        end
        UDEC_HOLD: begin
          if (bus.iReady) begin
            valid_d = 1'b0;
            // Start accepted with the handshake: no idle bubble.
            if (bus.iStart) begin
              state_d   = UDEC_RUN;
              cnt_clear = 1'b1;
            end else begin
              state_d = UDEC_IDLE;
            end
          end
        end
        default: begin
          state_d = UDEC_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= UDEC_IDLE;
      valid_q <= 1'b0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      bin_q   <= bin_d;
    end
  end

  assign bus.oBin   = bin_q;
  assign bus.oValid = valid_q;
  assign bus.oBusy  = (state_q == UDEC_RUN);

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Self-checking bench for unary_stream_decoder: one instance with
// BITWIDTH=8/LOGWIN=8 and one with BITWIDTH=8/LOGWIN=10.
module tb_unary_stream_decoder;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  unary_stream_decoder_if #(.BITWIDTH(8)) bus8 ();
  unary_stream_decoder_if #(.BITWIDTH(8)) bus10 ();

  unary_stream_decoder #(.BITWIDTH(8), .LOGWIN(8)) u_dut8 (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus8)
  );

  unary_stream_decoder #(.BITWIDTH(8), .LOGWIN(10)) u_dut10 (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus10)
  );

  int total;
  int passed;

  typedef struct {
    string name;
    int    sel;      // 0: LOGWIN=8 instance, 1: LOGWIN=10 instance
    int    logwin;
    int    pattern;  // see pat()
    bit    gapped;   // insert random iEn=0 cycles carrying iBit=1
    int    exp_bin;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic start, input logic en,
                       input logic b, input logic clr, input logic ready);
    if (sel == 0) begin
      bus8.iStart = start; bus8.iEn = en; bus8.iBit = b;
      bus8.iClr = clr; bus8.iReady = ready;
    end else begin
      bus10.iStart = start; bus10.iEn = en; bus10.iBit = b;
      bus10.iClr = clr; bus10.iReady = ready;
    end
  endtask

  // exp_bin < 0 skips the oBin comparison.
  task automatic check_out(input string name, input int sel, input int exp_bin,
                           input logic exp_valid, input logic exp_busy);
    logic [7:0] bin;
    logic       valid, busy;
    if (sel == 0) begin bin = bus8.oBin;  valid = bus8.oValid;  busy = bus8.oBusy;  end
    else          begin bin = bus10.oBin; valid = bus10.oValid; busy = bus10.oBusy; end
    if (exp_bin >= 0) check({name, " oBin"}, 32'(bin), 32'(exp_bin));
    check({name, " oValid"}, 32'(valid), 32'(exp_valid));
    check({name, " oBusy"}, 32'(busy), 32'(exp_busy));
  endtask

  function automatic logic pat(input int p, input int i);
    case (p)
      0:       return 1'b1;            // all ones
      1:       return 1'b0;            // all zeros
      2:       return (i % 2) == 0;    // 1010...
      3:       return i < 64;          // 64 ones
      4:       return i < 300;         // 300 ones
      default: return 1'b0;
    endcase
  endfunction

  // Feeds one full window; leaves the decoder in HOLD with no handshake.
  task automatic run_window(input string name, input int sel, input int logwin,
                            input int pattern, input bit gapped, input bit do_start,
                            input int exp_bin);
    int n;
    int gaps;
    n = 1 << logwin;
    gaps = 0;
    if (do_start) begin
      // iEn/iBit asserted during the start cycle must not be counted.
      drive(sel, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_out({name, " run"}, sel, -1, 1'b0, 1'b1);
    for (int i = 0; i < n; ) begin
      if (gapped && gaps < 600 && $urandom_range(0, 1) == 1) begin
        drive(sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        gaps++;
      end else begin
        if (i == n - 1) check_out({name, " pre-last"}, sel, -1, 1'b0, 1'b1);
        drive(sel, 1'b0, 1'b1, pat(pattern, i), 1'b0, 1'b0);
        step();
        i++;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out({name, " done"}, sel, exp_bin, 1'b1, 1'b0);
  endtask

  task automatic ack(input string name, input int sel, input logic start);
    drive(sel, start, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(sel, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out({name, " ack"}, sel, -1, 1'b0, start);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    vecs[0] = '{"all-ones",   0, 8,  0, 1'b0, 255};
    vecs[1] = '{"all-zeros",  0, 8,  1, 1'b0, 0};
    vecs[2] = '{"alternate",  0, 8,  2, 1'b0, 128};
    vecs[3] = '{"gapped-64",  0, 8,  3, 1'b1, 64};
    vecs[4] = '{"w10-300",    1, 10, 4, 1'b0, 75};
    vecs[5] = '{"w10-ones",   1, 10, 0, 1'b0, 255};

    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    check_out("reset8", 0, 0, 1'b0, 1'b0);
    check_out("reset10", 1, 0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;
    step();
    check_out("idle8", 0, 0, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      run_window(vecs[k].name, vecs[k].sel, vecs[k].logwin, vecs[k].pattern,
                 vecs[k].gapped, 1'b1, vecs[k].exp_bin);
      ack(vecs[k].name, vecs[k].sel, 1'b0);
    end

    // Backpressure: result held, samples and lone iStart ignored.
    run_window("bp", 0, 8, 2, 1'b0, 1'b1, 128);
    for (int k = 0; k < 10; k++) begin
      drive(0, 1'(k % 2), 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check_out("bp hold", 0, 128, 1'b1, 1'b0);
    end
    // Handshake plus iStart goes straight back to RUN.
    ack("b2b", 0, 1'b1);
    run_window("b2b", 0, 8, 0, 1'b0, 1'b0, 255);
    ack("b2b end", 0, 1'b0);

    // Abort in RUN; iStart in the same cycle is ignored.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 100; k++) begin
      drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("clr run", 0, 0, 1'b0, 1'b0);
    step();
    check_out("clr idle", 0, 0, 1'b0, 1'b0);
    run_window("post-clr", 0, 8, 0, 1'b0, 1'b1, 255);
    // Abort in HOLD clears the held result.
    drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_out("clr hold", 0, 0, 1'b0, 1'b0);

    // Async reset mid-HOLD: outputs drop before any clock edge.
    run_window("pre-rst", 0, 8, 2, 1'b0, 1'b1, 128);
    #2 rst_n = 1'b0;
    #1 check_out("rst hold", 0, 0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    // Async reset mid-RUN discards the partial window.
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 50; k++) begin
      drive(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("rst run", 0, 0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    check_out("post-rst idle", 0, 0, 1'b0, 1'b0);
    run_window("post-rst", 0, 8, 1, 1'b0, 1'b1, 0);
    ack("post-rst", 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
